// File: rtl/uart_char_rx.sv
// -----------------------------------------------------------------------------
// uart_char_rx
//
// 8N1 UART receiver that delivers each byte through a small first-word-fall-
// through FIFO. The FIFO head feeds the character-id encoder downstream.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (8..65535)
//   FIFO_DEPTH    received-byte buffer entries (power of two, 2..16)
//
// Ports
//   clk         system clock, all state on the rising edge
//   reset       asynchronous, active-low reset
//   rx          raw serial line (idle high, LSB first)
//   char_id     head-of-FIFO byte, 8'h00 while the FIFO is empty
//   char_valid  high while the FIFO holds at least one byte
//   char_ready  downstream accept; a byte pops on char_valid && char_ready
//   frame_err   one-cycle pulse when a stop bit is sampled low
//   overflow    one-cycle pulse when a good byte is dropped on a full FIFO
//   fifo_count  current FIFO occupancy
// -----------------------------------------------------------------------------
module uart_char_rx #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    output logic [7:0]                    char_id,
    output logic                          char_valid,
    input  logic                          char_ready,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    // Bit-period counter limits: full bit period and the middle of the start bit.
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    // -------------------------------------------------------------------------
    // Stage p0/p1: two-flop synchronizer; rxs is the only view of the line
    // -------------------------------------------------------------------------
    logic rx_p0;
    logic rxs;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_p0 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rxs   <= rx_p0;
        end
    end

    // -------------------------------------------------------------------------
    // Frame FSM: start qualification, data sampling, stop check
    // -------------------------------------------------------------------------
    state_t      state;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;

    // A good byte is pushed at the edge that samples a high stop bit.
    logic push_req;
    assign push_req = (state == STOP) && (bit_cnt == BIT_LAST) && rxs;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    bit_idx <= '0;
                    if (!rxs) begin
                        state <= START;
                    end
                end

                START: begin
                    // Re-check the line mid start bit so short glitches are
                    // dropped silently.
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        if (!rxs) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end

                DATA: begin
                    // Counting a full bit period from mid start bit lands each
                    // sample in the middle of the data bit.
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt            <= '0;
                        shift_reg[bit_idx] <= rxs;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end

                STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (rxs) begin
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end

                WAIT_IDLE: begin
                    // A low line here is a broken frame or break, not a start.
                    bit_cnt <= '0;
                    if (rxs) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Byte FIFO: first-word-fall-through, simultaneous push/pop on full allowed
    // -------------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic full;
    logic pop;
    logic push;

    assign full = (count == FULL_COUNT);
    assign pop  = char_valid && char_ready;
    // On a full FIFO a same-cycle pop frees the slot the push writes into.
    assign push = push_req && (!full || pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push_req && full && !pop;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage carries data only, so it is not reset; the output is masked
    // while empty instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= shift_reg;
        end
    end

    assign char_valid = (count != '0);
    assign char_id    = char_valid ? mem[rd_ptr] : 8'h00;
    assign fifo_count = count;

endmodule
